// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Registered command front-end and result stage for the external 4-bit
//   combinational ALU. Accepts one command per cmd_valid/cmd_ready handshake,
//   holds operands/opcode stable on alu_a/alu_b/alu_op, captures alu_y one
//   cycle later and presents it as res_y/res_zero under res_valid/res_ready.
//   Exactly one command in flight; one result per 3 cycles at best.
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_a, cmd_b, cmd_op   operands and opcode (00 ADD, 01 SUB, 10 NOT A, 11 AND)
//   cmd_use_acc            take operand A from acc[3:0] (accumulator builds only)
//   alu_a, alu_b, alu_op   registered drive to the ALU
//   alu_y                  ALU result
//   res_valid/res_ready    result handshake
//   res_y, res_zero        captured result and its zero flag
//   op_count               completed results, wraps mod 256
//
// Build option
//   ALU_SEQ_ACC_EN         adds the 8-bit accumulator loaded with alu_y at the
//                          capture edge; cmd_use_acc selects acc[3:0] as A.

module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    input  logic       cmd_use_acc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_y,
    output logic       res_zero,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       capture;
    logic       done;
    logic [3:0] a_sel;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low while rst is asserted so no command is taken in the reset cycle.
                cmd_ready = !rst;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_SEQ_ACC_EN
    logic [7:0] acc;
    logic [3:0] unused_acc_hi;

    always_ff @(posedge clk) begin
        if (rst)          acc <= '0;
        else if (capture) acc <= alu_y;
    end

    always_comb begin
        a_sel = cmd_use_acc ? acc[3:0] : cmd_a;
    end

    // Only the low nibble can feed operand A.
    assign unused_acc_hi = acc[7:4];
`else
    logic unused_use_acc;

    always_comb begin
        a_sel = cmd_a;
    end

    assign unused_use_acc = cmd_use_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            res_y    <= '0;
            res_zero <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                alu_a  <= a_sel;
                alu_b  <= cmd_b;
                alu_op <= cmd_op;
            end
            if (capture) begin
                res_y    <= alu_y;
                res_zero <= (alu_y == 8'h00);
            end
            if (done) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;
    logic       cmd_use_acc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_y;
    logic       res_zero;
    logic [7:0] op_count;

    int tests  = 0;
    int failed = 0;
    int unsigned cyc = 0;

    // Reference state: completed-result count and accumulator contents.
    logic [7:0] m_cnt;
    logic [7:0] m_acc;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_zero(res_zero), .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
        int r;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = 255 - int'(a);
            default: r = int'(a & b);
        endcase
        return 8'(r);
    endfunction

    // The combinational ALU the sequencer drives.
    assign alu_y = alu_ref(alu_a, alu_b, alu_op);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        step();
        rst = 1'b0;
        m_cnt = '0;
        m_acc = '0;
        step();
    endtask

    // One full command/result transaction; stall = cycles res_ready is held low in HOLD.
    // During EXEC/HOLD a junk command is kept valid to show it is ignored.
    task automatic txn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic ua, input int unsigned stall, output logic [7:0] got);
        logic [3:0] ea;
        logic [7:0] ey;
        ea = (ACC_EN && ua) ? m_acc[3:0] : a;
        ey = alu_ref(ea, b, op);
        tests++;
        if (cmd_ready !== 1'b1) begin
            failed++; $display("FAIL txn_ready_idle: got %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua;
        res_ready = (stall == 0);
        step();
        cmd_a = ~a; cmd_b = ~b; cmd_op = ~op; cmd_use_acc = ~ua;
        tests++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
            failed++; $display("FAIL txn_exec_flags: got ready=%b valid=%b expected 0 0", cmd_ready, res_valid);
        end
        tests++;
        if ({alu_a, alu_b, alu_op} !== {ea, b, op}) begin
            failed++; $display("FAIL txn_alu_drive: got a=%h b=%h op=%h expected a=%h b=%h op=%h",
                               alu_a, alu_b, alu_op, ea, b, op);
        end
        step();
        got = res_y;
        if (ACC_EN) m_acc = ey;
        tests++;
        if (res_valid !== 1'b1 || res_y !== ey || res_zero !== (ey == 8'h00) || cmd_ready !== 1'b0) begin
            failed++; $display("FAIL txn_result: got v=%b y=%h z=%b rdy=%b expected v=1 y=%h z=%b rdy=0",
                               res_valid, res_y, res_zero, cmd_ready, ey, (ey == 8'h00));
        end
        repeat (stall) begin
            step();
            tests++;
            if (res_valid !== 1'b1 || res_y !== ey || cmd_ready !== 1'b0 ||
                alu_a !== ea || op_count !== m_cnt) begin
                failed++; $display("FAIL txn_stall: got v=%b y=%h rdy=%b a=%h cnt=%0d expected v=1 y=%h rdy=0 a=%h cnt=%0d",
                                   res_valid, res_y, cmd_ready, alu_a, op_count, ey, ea, m_cnt);
            end
        end
        res_ready = 1'b1;
        cmd_valid = 1'b0;
        step();
        m_cnt = m_cnt + 8'd1;
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== m_cnt) begin
            failed++; $display("FAIL txn_done: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=%0d",
                               res_valid, cmd_ready, op_count, m_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_use_acc = 1'b0;
        step();
        step();
        tests++;
        if (cmd_ready !== 1'b0) begin
            failed++; $display("FAIL reset_ready: got %b expected 0", cmd_ready);
        end
        tests++;
        if ({res_valid, res_y, res_zero, op_count, alu_a, alu_b, alu_op} !== 28'h0) begin
            failed++; $display("FAIL reset_values: got v=%b y=%h z=%b cnt=%0d a=%h b=%h op=%h expected all 0",
                               res_valid, res_y, res_zero, op_count, alu_a, alu_b, alu_op);
        end
        rst = 1'b0;
        m_cnt = '0;
        m_acc = '0;
        step();
        tests++;
        if (cmd_ready !== 1'b1) begin
            failed++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] y;
        txn(4'h9, 4'h8, 2'd0, 1'b0, 0, y);
        tests++;
        if (y !== 8'h11) begin failed++; $display("FAIL add_9_8: got %h expected 11", y); end
        tests++;
        if (op_count !== 8'd1) begin failed++; $display("FAIL first_count: got %0d expected 1", op_count); end
        txn(4'h2, 4'h5, 2'd1, 1'b0, 0, y);
        tests++;
        if (y !== 8'hFD) begin failed++; $display("FAIL sub_2_5: got %h expected fd", y); end
        txn(4'hC, 4'h3, 2'd3, 1'b0, 0, y);
        tests++;
        if (y !== 8'h00 || res_zero !== 1'b1) begin
            failed++; $display("FAIL and_c_3: got y=%h z=%b expected 00 1", y, res_zero);
        end
        txn(4'h3, 4'h0, 2'd2, 1'b0, 0, y);
        tests++;
        if (y !== 8'hFC) begin failed++; $display("FAIL not_3: got %h expected fc", y); end
    endtask

    task automatic test_backpressure();
        logic [7:0] y;
        logic [7:0] cnt0;
        cnt0 = op_count;
        txn(4'h6, 4'h4, 2'd0, 1'b0, 10, y);
        tests++;
        if (op_count !== cnt0 + 8'd1) begin
            failed++; $display("FAIL bp_count_once: got %0d expected %0d", op_count, cnt0 + 8'd1);
        end
        step();
        step();
        tests++;
        if (op_count !== cnt0 + 8'd1 || res_valid !== 1'b0) begin
            failed++; $display("FAIL bp_count_after: got cnt=%0d v=%b expected %0d 0", op_count, res_valid, cnt0 + 8'd1);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_a = 4'h7; cmd_b = 4'h7; cmd_op = 2'd0; cmd_use_acc = 1'b0;
        res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        tests++;
        if ({res_valid, res_y, res_zero, op_count, alu_a, alu_b, alu_op} !== 28'h0 || cmd_ready !== 1'b0) begin
            failed++; $display("FAIL midreset_values: got v=%b y=%h z=%b cnt=%0d a=%h b=%h op=%h rdy=%b expected 0",
                               res_valid, res_y, res_zero, op_count, alu_a, alu_b, alu_op, cmd_ready);
        end
        rst = 1'b0;
        m_cnt = '0;
        m_acc = '0;
        repeat (3) begin
            step();
            tests++;
            if (res_valid !== 1'b0 || op_count !== 8'd0 || cmd_ready !== 1'b1) begin
                failed++; $display("FAIL midreset_idle: got v=%b cnt=%0d rdy=%b expected 0 0 1", res_valid, op_count, cmd_ready);
            end
        end
        res_ready = 1'b0;
    endtask

    task automatic test_acc();
        logic [7:0] y;
        do_reset();
        txn(4'h5, 4'h6, 2'd0, 1'b0, 0, y);
        txn(4'h0, 4'h2, 2'd0, 1'b1, 0, y);
        tests++;
        if (y !== (ACC_EN ? 8'h0D : 8'h02)) begin
            failed++; $display("FAIL acc_chain: got %h expected %h", y, (ACC_EN ? 8'h0D : 8'h02));
        end
    endtask

    task automatic test_random();
        logic [7:0] y;
        for (int i = 0; i < 40; i++) begin
            txn(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                $urandom_range(0, 3), y);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] y;
        int unsigned c0;
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 256; i++) begin
            txn(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 0, y);
        end
        tests++;
        if (op_count !== 8'd0) begin failed++; $display("FAIL wrap_count: got %0d expected 0", op_count); end
        tests++;
        if (cyc - c0 != 768) begin failed++; $display("FAIL throughput: got %0d cycles expected 768", cyc - c0); end
    endtask

    initial begin
        m_cnt = '0;
        m_acc = '0;
        test_reset();
        test_reset_mid();
        test_directed();
        test_backpressure();
        test_acc();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
